// File: rtl/sumador_serie_n_bits.sv
// ----------------------------------------------------------------------------
// sumador_completo_1_bit
//   One-bit full adder cell: {c_out, s} = x + y + c_in.
//   Ports:
//     x, y   : operand bits
//     c_in   : carry in
//     s      : sum bit
//     c_out  : carry out
//
// sumador_serie_n_bits
//   Bit-serial N-bit adder. Reuses a single full adder cell one bit per clock,
//   LSB first, with operand shift registers and a carry flip-flop.
//   The start edge is edge 0; bits 0..N-1 are computed on edges 1..N.
//   Ports:
//     clk    : system clock, rising edge
//     rst    : synchronous reset, active-high
//     start  : operation request, honoured only while busy is low
//     a, b   : N-bit operands, captured on the accepted start edge
//     c_in   : carry in, captured on the accepted start edge
//     busy   : high while an addition is in progress
//     done   : one-cycle pulse when s/c_out/ov are updated
//     s      : registered N-bit sum
//     c_out  : registered carry out of bit N-1
//     ov     : registered two's-complement overflow
// ----------------------------------------------------------------------------
module sumador_completo_1_bit (
    input  logic x,
    input  logic y,
    input  logic c_in,
    output logic s,
    output logic c_out
);

    logic w_p;

    assign w_p   = x ^ y;
    assign s     = w_p ^ c_in;
    assign c_out = (x & y) | (c_in & w_p);

endmodule

module sumador_serie_n_bits #(
    parameter int unsigned N = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         c_in,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] s,
    output logic         c_out,
    output logic         ov
);

    localparam int unsigned CntW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [0:0] {StReposo, StSumando} state_e;

    state_e            r_state;
    logic [N-1:0]      r_a_sr;
    logic [N-1:0]      r_b_sr;
    logic [N-1:0]      r_r_sr;
    logic              r_carry;
    logic              r_msb_cin;
    logic [CntW-1:0]   r_cnt;
    logic              r_busy;
    logic              r_done;
    logic [N-1:0]      r_s;
    logic              r_c_out;
    logic              r_ov;

    logic              w_s;
    logic              w_c_out;
    logic [N-1:0]      w_r_next;

    sumador_completo_1_bit u_fa (
        .x     (r_a_sr[0]),
        .y     (r_b_sr[0]),
        .c_in  (r_carry),
        .s     (w_s),
        .c_out (w_c_out)
    );

    // Result register with the current sum bit entering at the MSB.
    assign w_r_next = {w_s, r_r_sr[N-1:1]};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= StReposo;
            r_a_sr    <= '0;
            r_b_sr    <= '0;
            r_r_sr    <= '0;
            r_carry   <= 1'b0;
            r_msb_cin <= 1'b0;
            r_cnt     <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_s       <= '0;
            r_c_out   <= 1'b0;
            r_ov      <= 1'b0;
        end else begin
            r_done <= 1'b0;
            unique case (r_state)
                StReposo: begin
                    if (start) begin
                        r_a_sr  <= a;
                        r_b_sr  <= b;
                        r_carry <= c_in;
                        r_cnt   <= '0;
                        r_busy  <= 1'b1;
                        r_state <= StSumando;
                    end
                end
                StSumando: begin
                    r_a_sr  <= {1'b0, r_a_sr[N-1:1]};
                    r_b_sr  <= {1'b0, r_b_sr[N-1:1]};
                    r_r_sr  <= w_r_next;
                    r_carry <= w_c_out;
                    r_cnt   <= r_cnt + CntW'(1);
                    // Carry out of bit N-2 is the carry into the MSB.
                    if (r_cnt == CntW'(N - 2)) begin
                        r_msb_cin <= w_c_out;
                    end
                    if (r_cnt == CntW'(N - 1)) begin
                        r_s     <= w_r_next;
                        r_c_out <= w_c_out;
                        r_ov    <= r_msb_cin ^ w_c_out;
                        r_done  <= 1'b1;
                        r_busy  <= 1'b0;
                        r_state <= StReposo;
                    end
                end
                default: r_state <= StReposo;
            endcase
        end
    end

    assign busy  = r_busy;
    assign done  = r_done;
    assign s     = r_s;
    assign c_out = r_c_out;
    assign ov    = r_ov;

endmodule

// File: tb/tb_sumador_serie_n_bits.sv
// ----------------------------------------------------------------------------
// tb_sumador_serie_n_bits
//   Directed bench for the bit-serial adder. The driver pushes the expected
//   {c_out, ov, s} for every accepted operation; a monitor pops and compares
//   whenever done is seen. Handshake timing is checked by the driver.
// ----------------------------------------------------------------------------
module tb_sumador_serie_n_bits;

    localparam int unsigned N = 8;

    logic         clk;
    logic         rst;
    logic         start;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic         c_in;
    logic         busy;
    logic         done;
    logic [N-1:0] s;
    logic         c_out;
    logic         ov;

    int checks;
    int errors;

    // Expected result packed as {c_out, ov, s}.
    logic [N+1:0] sb[$];
    logic [N+1:0] last_exp;

    sumador_serie_n_bits #(.N(N)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .c_in  (c_in),
        .busy  (busy),
        .done  (done),
        .s     (s),
        .c_out (c_out),
        .ov    (ov)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    // Monitor: scoreboard comparison on every done pulse.
    always @(negedge clk) begin
        if (!rst && done) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: got done=1, expected no pending result");
            end else begin
                logic [N+1:0] exp;
                exp = sb.pop_front();
                check("result", {22'd0, c_out, ov, s}, {22'd0, exp});
                last_exp = exp;
            end
        end
    end

    // Wait (bounded) for done, counting cycles with busy high; caller is at posedge+#1.
    task automatic wait_done(input string name);
        int n;
        int n_busy;
        n = 0;
        n_busy = 0;
        while (!done && n < 40) begin
            if (busy) n_busy++;
            @(posedge clk);
            #1;
            n++;
        end
        check({name, "_done_seen"}, {31'd0, done}, 32'd1);
        check({name, "_busy_cycles"}, n_busy, N);
        check({name, "_busy_low_at_done"}, {31'd0, busy}, 32'd0);
    endtask

    // Issue one operation and run it to completion.
    task automatic do_op(input string name, input logic [N-1:0] ta, input logic [N-1:0] tb,
                         input logic tc, input logic [N+1:0] exp);
        logic [N+1:0] held;
        held = last_exp;
        @(negedge clk);
        a = ta;
        b = tb;
        c_in = tc;
        start = 1'b1;
        sb.push_back(exp);
        @(posedge clk);
        #1;
        start = 1'b0;
        a = N'($urandom);
        b = N'($urandom);
        c_in = 1'($urandom);
        check({name, "_busy_after_start"}, {31'd0, busy}, 32'd1);
        check({name, "_outputs_held"}, {22'd0, c_out, ov, s}, {22'd0, held});
        wait_done(name);
        @(posedge clk);
        #1;
        check({name, "_done_one_cycle"}, {31'd0, done}, 32'd0);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        last_exp = '0;
        rst = 1'b1;
        start = 1'b0;
        a = '0;
        b = '0;
        c_in = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_busy", {31'd0, busy}, 32'd0);
        check("reset_done", {31'd0, done}, 32'd0);
        check("reset_outs", {22'd0, c_out, ov, s}, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        do_op("op_0f_01", 8'h0F, 8'h01, 1'b0, {1'b0, 1'b0, 8'h10});
        do_op("op_ff_01", 8'hFF, 8'h01, 1'b0, {1'b1, 1'b0, 8'h00});
        do_op("op_7f_01", 8'h7F, 8'h01, 1'b0, {1'b0, 1'b1, 8'h80});
        do_op("op_80_80_c", 8'h80, 8'h80, 1'b1, {1'b1, 1'b1, 8'h01});

        // Start while busy is ignored; start in the done cycle is accepted.
        @(negedge clk);
        a = 8'h12;
        b = 8'h34;
        c_in = 1'b0;
        start = 1'b1;
        sb.push_back({1'b0, 1'b0, 8'h46});
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        a = 8'hFF;
        b = 8'hFF;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        check("busy_start_ignored", {31'd0, busy}, 32'd1);
        begin
            int n;
            n = 0;
            while (!done && n < 40) begin
                @(posedge clk);
                #1;
                n++;
            end
            check("first_op_done", {31'd0, done}, 32'd1);
        end
        a = 8'h01;
        b = 8'h01;
        c_in = 1'b0;
        start = 1'b1;
        sb.push_back({1'b0, 1'b0, 8'h02});
        @(posedge clk);
        #1;
        start = 1'b0;
        check("done_cycle_start_busy", {31'd0, busy}, 32'd1);
        check("done_cycle_start_done", {31'd0, done}, 32'd0);
        check("done_cycle_start_held", {22'd0, c_out, ov, s}, {22'd0, 2'b00, 8'h46});
        wait_done("op_01_01");

        // Reset in the middle of an operation discards it.
        @(negedge clk);
        a = 8'hAA;
        b = 8'h55;
        c_in = 1'b0;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("midreset_busy", {31'd0, busy}, 32'd0);
        check("midreset_done", {31'd0, done}, 32'd0);
        check("midreset_outs", {22'd0, c_out, ov, s}, 32'd0);
        last_exp = '0;
        @(negedge clk);
        rst = 1'b0;
        repeat (12) @(posedge clk);
        #1;
        check("midreset_no_done", {31'd0, done}, 32'd0);

        do_op("op_aa_55_c", 8'hAA, 8'h55, 1'b1, {1'b1, 1'b0, 8'h00});
        do_op("op_40_40", 8'h40, 8'h40, 1'b0, {1'b0, 1'b1, 8'h80});

        repeat (3) @(posedge clk);
        check("scoreboard_empty", sb.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
